// File: rtl/sw_pkg.sv
// Shared constants and helpers for the slide-switch input conditioning path.
package sw_pkg;

    localparam int SW_WIDTH            = 10;
    localparam int CLK_FREQ_HZ         = 50_000_000;
    localparam int DEBOUNCE_US_DEFAULT = 10_000;

    // Cycles a synchronised level must persist before it is accepted.
    // The clock is divided down to cycles-per-microsecond first so the
    // product stays well inside 32 bits for realistic clock rates.
    function automatic int stable_cycles(input int freq, input int us);
        int cyc;
        cyc = (freq / 1_000_000) * us;
        return (cyc < 1) ? 1 : cyc;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, agreement counter, accepted level
// and registered rise/fall strobes.
module debounce_bit #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          db_q,   db_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Any sample agreeing with the accepted level restarts the count, so only
    // an uninterrupted run of STABLE_CYCLES disagreeing samples flips db.
    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            db_d   = s2_q;
            rise_d = s2_q;
            fall_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= sw_raw;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_db   = db_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces the slide-switch bus bit by bit, producing clean
// levels for the LED logic plus per-bit edge strobes and a combined change flag.
module switch_debouncer
    import sw_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int CLK_FREQ_HZ   = sw_pkg::CLK_FREQ_HZ,
    parameter int DEBOUNCE_US   = DEBOUNCE_US_DEFAULT,
    parameter int STABLE_CYCLES = stable_cycles(CLK_FREQ_HZ, DEBOUNCE_US)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .STABLE_CYCLES(STABLE_CYCLES)
            ) u_bit (
                .clk    (clk),
                .rst    (rst),
                .sw_raw (sw_raw[gi]),
                .sw_db  (sw_db[gi]),
                .sw_rise(sw_rise[gi]),
                .sw_fall(sw_fall[gi])
            );
        end
    endgenerate

    // Strobes are already registered, so the OR is aligned with them and is
    // naturally low during and after reset.
    assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input conditioning stage directly upstream of the switch-to-LED reflection top level.
- Synchronises the raw asynchronous slide-switch bus SW[9:0] into the system clock domain and debounces each bit independently.
- Produces a clean level bus for LEDR plus one-cycle rise/fall event strobes for later sequential consumers.

Parameters:
- WIDTH, 10, number of switch bits.
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- DEBOUNCE_US, 10_000, required stable time in microseconds.
- STABLE_CYCLES, CLK_FREQ_HZ/1_000_000*DEBOUNCE_US, consecutive agreeing cycles before a bit is accepted. May be overridden directly; legal range ≥ 1. Benches use 4.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  WIDTH  asynchronous switch levels, from board SW.
- sw_db  output  WIDTH  debounced switch levels, to LEDR logic.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 0→1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 1→0.
- sw_changed  output  1  OR of all sw_rise and sw_fall bits, same cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset (rst=1 at a rising edge):
  - Both synchroniser stages, all counters, sw_db, sw_rise, sw_fall and sw_changed are cleared to 0.
  - Reset dominates every other event that cycle.
- Reset mid-operation: in-progress counts are discarded. After rst deasserts, a switch held at 1 is re-accepted through the full latency path and produces an sw_rise pulse.
- Synchroniser: two flops per bit (s1 ← sw_raw, s2 ← s1). No logic between the stages.
- Per-bit counter rule, evaluated every rising edge with cnt of width $clog2(STABLE_CYCLES+1):
  - If s2 == sw_db: cnt ← 0.
  - If s2 != sw_db and cnt == STABLE_CYCLES-1: sw_db ← s2, cnt ← 0, pulse asserted.
  - Otherwise (s2 != sw_db): cnt ← cnt+1.
- Latency: number the first rising edge that samples a new, held sw_raw value as edge 1. sw_db changes after edge STABLE_CYCLES+2 and holds from then on.
- Glitch rejection:
  - Any return of s2 to the sw_db value before the count completes clears cnt; no output change.
  - Pulses shorter than STABLE_CYCLES cycles at s2 are never propagated.
- Strobes:
  - sw_rise and sw_fall are registered and asserted in exactly the cycle sw_db changes.
  - Each strobe lasts one cycle.
  - sw_rise and sw_fall are mutually exclusive per bit.
- Independence: bits never interact; several bits may update in the same cycle. sw_changed is high for exactly one cycle in that case.
- Boundary STABLE_CYCLES=1: accepted on the first cycle s2 differs, giving 3-edge latency.
- Counter saturation is impossible: cnt never exceeds STABLE_CYCLES-1.

Decomposition:
- Package sw_pkg:
  - SW_WIDTH = 10.
  - CLK_FREQ_HZ = 50_000_000.
  - Function stable_cycles(freq, us) returning int.
  - DEBOUNCE_US_DEFAULT constant.
- Sub-module debounce_bit:
  - Contains one synchroniser pair, counter, level flop and rise/fall flops.
  - Parameter STABLE_CYCLES.
- switch_debouncer instantiates WIDTH copies in a generate loop and ORs the strobes into sw_changed.

Test Plan:
1. Reset value: hold rst=1 for 3 cycles with sw_raw=10'h3FF; release → sw_db=0 and no strobes during reset. With STABLE_CYCLES=4, sw_db=10'h3FF after edge 6 post-release, with sw_rise=10'h3FF and sw_changed=1 for one cycle.
2. Latency: STABLE_CYCLES=4, sw_raw 0→10'b0000000001 held → sw_db[0]=1 exactly after edge 6. sw_rise[0] pulses one cycle, sw_fall=0.
3. Glitch rejection: sw_raw[5] high for 3 cycles then low → sw_db stays 0 and no strobes. Then high for 5 cycles → accepted, sw_rise[5] pulses.
4. Bounce: toggle sw_raw[9] every cycle for 20 cycles, then hold at 1 → single sw_rise[9] pulse, 6 edges after the final toggle; no intermediate changes.
5. Multi-bit: sw_raw 10'h3FF→10'b1010101010 → sw_fall=10'b0101010101 for one cycle, sw_rise=0, sw_changed one cycle, sw_db=10'b1010101010.
6. Reset mid-count: start sw_raw[2] 0→1, assert rst after 2 counting cycles, release → sw_db[2]=0 during reset, then re-accepted after full 6-edge latency with one sw_rise[2].
